key_debouncer: RTL
==================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter DIV, default 50000, clock cycles per settle tick (legal range 1..65535).
REQ-002 SHALL have parameter SETTLE_TICKS, default 10, settle ticks a level must hold before acceptance (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port key_in  input  1  raw asynchronous key/button level.
REQ-006 SHALL have port key_level  output  1  debounced key level.
REQ-007 SHALL have port key_press  output  1  one-cycle pulse on accepted 0->1.
REQ-008 SHALL have port key_release  output  1  one-cycle pulse on accepted 1->0.
REQ-009 SHALL have port busy  output  1  high while a level change is being qualified.

Function
REQ-010 SHALL pass key_in through a two-flop synchronizer; the second flop output key_s is the only internal view of the key.
REQ-011 SHALL contain a prescaler (0..DIV-1) emitting a one-cycle tick when it reaches DIV-1, then wrapping to 0.
REQ-012 SHALL contain a 16-bit settle down-counter that loads SETTLE_TICKS on start, decrements by 1 per tick while nonzero, and asserts done while zero.
REQ-013 SHALL clear the prescaler to 0 on every counter load, so qualification lasts exactly SETTLE_TICKS*DIV cycles.
REQ-014 SHALL hold the settle counter at zero (no wrap) until the next load.
REQ-015 SHALL implement FSM states LOW, CHECK_HIGH, HIGH, CHECK_LOW.
REQ-016 LOW: key_s=1 -> CHECK_HIGH with counter load; otherwise stay.
REQ-017 CHECK_HIGH: key_s=0 -> LOW (bounce, no pulse); else done=1 -> HIGH with key_press=1 for that one cycle.
REQ-018 HIGH: key_s=0 -> CHECK_LOW with counter load; otherwise stay.
REQ-019 CHECK_LOW: key_s=1 -> HIGH (bounce, no pulse); else done=1 -> LOW with key_release=1 for that one cycle.
REQ-020 SHALL give a bounce priority over done when both occur in the same cycle.
REQ-021 SHALL drive key_level=1 in HIGH and CHECK_LOW, 0 in LOW and CHECK_HIGH.
REQ-022 SHALL drive busy=1 exactly in CHECK_HIGH and CHECK_LOW.
REQ-023 SHALL register key_press and key_release so they never both assert in one cycle.
REQ-024 SHALL assert key_press SETTLE_TICKS*DIV+3 clock edges after the first edge that samples key_in=1 from a stable LOW, given no bounce.

Reset
REQ-025 SHALL on rst=1 set state LOW, synchronizer flops 0, prescaler 0, settle counter SETTLE_TICKS, and all outputs 0 on the next edge.
REQ-026 SHALL produce no key_press/key_release on reset entry or exit, including reset during a CHECK state.
REQ-027 SHALL, after reset release with key_in held 1, qualify the level normally from LOW (key_press after full settle time).

Structure
REQ-028 SHALL place the state encoding (2-bit), counter width constant (16) and default DIV/SETTLE_TICKS in a shared package key_debouncer_pkg.
REQ-029 SHALL implement prescaler plus settle counter as one sub-module settle_timer (ports clk, rst, load, done), instantiated once.

Verification
REQ-030 DIV=4, SETTLE_TICKS=10, key_in 0->1 held -> key_press single pulse 43 edges later, key_level=1, busy high 40 cycles.
REQ-031 Same params, key_in high 20 cycles then low -> no key_press, key_level stays 0, busy returns 0.
REQ-032 From HIGH, key_in low held -> key_release single pulse after 43 edges, key_level=0.
REQ-033 In CHECK_HIGH, key_s falls on the cycle done rises -> return to LOW, no key_press.
REQ-034 rst=1 pulse mid CHECK_HIGH with key_in held 1 -> outputs 0 next edge, no pulse; key_press 43 edges after rst release.
REQ-035 DIV=1, SETTLE_TICKS=1 -> key_press 4 edges after key_in rises; no counter wrap.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg: shared state encoding, counter width and default timing for the key debouncer.
// Contents:
//   CNT_W             - width of the prescaler and settle counter
//   DEF_DIV           - default clock cycles per settle tick
//   DEF_SETTLE_TICKS  - default settle ticks a new level must hold
//   state_t           - 2-bit debouncer FSM state
package key_debouncer_pkg;

    localparam int CNT_W            = 16;
    localparam int DEF_DIV          = 50000;
    localparam int DEF_SETTLE_TICKS = 10;

    typedef enum logic [1:0] {
        S_LOW        = 2'd0,
        S_CHECK_HIGH = 2'd1,
        S_HIGH       = 2'd2,
        S_CHECK_LOW  = 2'd3
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// settle_timer: prescaler plus settle down-counter that measures how long a new key level has held.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   load - restart a qualification window (counter to SETTLE_TICKS, prescaler to 0)
//   done - high while the settle counter is zero
module settle_timer
    import key_debouncer_pkg::*;
#(
    parameter int DIV          = DEF_DIV,
    parameter int SETTLE_TICKS = DEF_SETTLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam logic [CNT_W-1:0] PRE_MAX  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_TICKS);

    logic [CNT_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    // Clearing the prescaler on load makes every window exactly SETTLE_TICKS*DIV cycles;
    // the counter parks at zero instead of wrapping.
    always_comb begin
        tick  = pre_q == PRE_MAX;
        pre_d = (load || tick) ? '0 : pre_q + 1'b1;
        cnt_d = load ? LOAD_VAL : (tick && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        done  = cnt_q == '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= LOAD_VAL;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes a raw key and accepts a level change only after it holds for the settle time.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   key_in      - raw asynchronous key level
//   key_level   - debounced key level
//   key_press   - one-cycle pulse on an accepted 0->1
//   key_release - one-cycle pulse on an accepted 1->0
//   busy        - high while a level change is being qualified
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int DIV          = DEF_DIV,
    parameter int SETTLE_TICKS = DEF_SETTLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic busy
);

    state_t state_q, state_d;
    logic   sync1_q, sync1_d;
    logic   key_s_q, key_s_d;
    logic   press_q, press_d;
    logic   release_q, release_d;
    logic   load;
    logic   done;

    settle_timer #(
        .DIV          (DIV),
        .SETTLE_TICKS (SETTLE_TICKS)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .done (done)
    );

    // A bounce back to the old level is tested before done, so it wins when both coincide.
    always_comb begin
        sync1_d   = key_in;
        key_s_d   = sync1_q;
        state_d   = state_q;
        load      = 1'b0;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_LOW: begin
                if (key_s_q) begin
                    state_d = S_CHECK_HIGH;
                    load    = 1'b1;
                end
            end
            S_CHECK_HIGH: begin
                if (!key_s_q) begin
                    state_d = S_LOW;
                end else if (done) begin
                    state_d = S_HIGH;
                    press_d = 1'b1;
                end
            end
            S_HIGH: begin
                if (!key_s_q) begin
                    state_d = S_CHECK_LOW;
                    load    = 1'b1;
                end
            end
            default: begin
                if (key_s_q) begin
                    state_d = S_HIGH;
                end else if (done) begin
                    state_d   = S_LOW;
                    release_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LOW;
            sync1_q   <= 1'b0;
            key_s_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            key_s_q   <= key_s_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_level   = state_q == S_HIGH || state_q == S_CHECK_LOW;
    assign busy        = state_q == S_CHECK_HIGH || state_q == S_CHECK_LOW;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule
